// File: rtl/display_7seg_5bits.sv
// display_7seg_5bits: shows a 5-bit value (0..31) in decimal on the two lower
// digits of a 4-digit multiplexed seven-segment display. The two upper digits
// are scanned but kept dark, so every digit gets the same duty cycle.
// The value is captured once per scan frame, at the edge that selects the units
// digit. A frame therefore never mixes digits from two different values.
module display_7seg_5bits #(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] valor_i,
   input  logic       en_i,
   output logic [6:0] seg_o,
   output logic [3:0] an_o,
   output logic       dp_o
);

   localparam int            CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_DARK = 7'b1111111;
   localparam logic [3:0] AN_DARK  = 4'b1111;

   logic [CW-1:0] r_div_cnt;
   logic [1:0]    r_idx;
   logic [4:0]    r_snap;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;

   logic          w_tc;
   logic [1:0]    w_idx_next;
   logic [4:0]    w_snap_next;
   logic [3:0]    w_tens;
   logic [3:0]    w_units;
   logic [6:0]    w_seg_next;
   logic [3:0]    w_an_next;

   // Active-low glyph for one decimal digit, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = SEG_DARK;
      endcase
      return g;
   endfunction

   assign w_tc = (r_div_cnt == TC_VAL);

   // Next index and the snapshot the display will use after this edge. The
   // output register looks at these, so the units digit appears together with
   // the freshly captured value rather than one slot late.
   always_comb begin
      w_idx_next  = r_idx;
      w_snap_next = r_snap;
      if (w_tc) begin
         w_idx_next = r_idx + 2'd1;
         if (r_idx == 2'd3) begin
            w_snap_next = valor_i;
         end
      end
   end

   // Binary to two BCD digits; the value never exceeds 31, so tens is 0..3.
   always_comb begin
      w_tens  = 4'd0;
      w_units = 4'(w_snap_next);
      if (w_snap_next >= 5'd30) begin
         w_tens  = 4'd3;
         w_units = 4'(w_snap_next - 5'd30);
      end else if (w_snap_next >= 5'd20) begin
         w_tens  = 4'd2;
         w_units = 4'(w_snap_next - 5'd20);
      end else if (w_snap_next >= 5'd10) begin
         w_tens  = 4'd1;
         w_units = 4'(w_snap_next - 5'd10);
      end
   end

   // Anode/segment pattern for the next index; dark when disabled or unused.
   always_comb begin
      w_an_next  = AN_DARK;
      w_seg_next = SEG_DARK;
      if (en_i) begin
         case (w_idx_next)
            2'd0: begin
               w_an_next  = 4'b1110;
               w_seg_next = f_glyph(w_units);
            end
            2'd1: begin
               if (!(BLANK_LZ && (w_tens == 4'd0))) begin
                  w_an_next  = 4'b1101;
                  w_seg_next = f_glyph(w_tens);
               end
            end
            default: begin
               w_an_next  = AN_DARK;
               w_seg_next = SEG_DARK;
            end
         endcase
      end
   end

   // Refresh divider, digit index and once-per-frame value snapshot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_div_cnt <= '0;
         r_idx     <= 2'd3;
         r_snap    <= 5'd0;
      end else begin
         r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
         r_idx     <= w_idx_next;
         r_snap    <= w_snap_next;
      end
   end

   // Registered display drive; reloaded every cycle so enable acts at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_an  <= AN_DARK;
         r_seg <= SEG_DARK;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
      end
   end

   assign an_o  = r_an;
   assign seg_o = r_seg;
   assign dp_o  = 1'b1;

endmodule
